// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame shape.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STOP_BITS            = 1;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous first-word-fall-through FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_COUNT);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_rx.sv
// UART 8N1 receive front end: pin synchroniser, mid-bit sampling FSM,
// sticky error flags and a FWFT receive FIFO.
module io_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          SI_ClkIn,
  input  logic                          SI_Reset_N,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [TW-1:0]    HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]    BIT_M1   = TW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 push_q;
  logic [DATA_BITS-1:0] push_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_accepts;

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  // The push lands one edge after the stop sample; only pops can happen in
  // between, so deciding acceptance at the stop sample is safe.
  assign fifo_accepts = !fifo_full || (rd_en && !fifo_empty);

  always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
    if (!SI_Reset_N) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // Flag sets below override this clear when both occur together.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            timer <= TW'(1);
            state <= ST_START;
          end
        end
        ST_START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == BIT_M1) begin
            timer <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (timer == BIT_M1) begin
            timer <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              if (fifo_accepts) begin
                push_q    <= 1'b1;
                push_data <= shift;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (SI_ClkIn),
    .rst_n     (SI_Reset_N),
    .push      (push_q),
    .push_data (push_data),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .count     (rx_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rx_empty = fifo_empty;
  assign rx_full  = fifo_full;

endmodule

// File: tb/tb_io_uart_rx.sv
// Self-checking bench for io_uart_rx with a queue-based reference model.
module tb_io_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic [4:0] rx_count;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;

  always #5 clk = ~clk;

  io_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .SI_ClkIn   (clk),
    .SI_Reset_N (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // One frame on the pin, one bit per CPB cycles, driven on falling edges.
  // pop_k: cycle at which rd_en is raised for one cycle (stop-sample cycle is 153).
  // abort_k: stop driving at this cycle without updating the model.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit lat_chk,
                            input int pop_k, input int abort_k);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      if (k == abort_k) return;
      rx = f[k / 16];
      rd_en = 1'b0;
      if (k == pop_k) begin
        checks++;
        if (rd_data !== q[0])
          $display("FAIL stop_pop_head: got %02h expected %02h", rd_data, q[0]);
        if (rd_data !== q[0]) errors++;
        rd_en = 1'b1;
        void'(q.pop_front());
      end
      @(negedge clk);
      if (lat_chk && k == 153) begin
        checks++;
        if (rx_empty !== 1'b1) begin
          errors++;
          $display("FAIL push_latency_early: rx_empty got %b expected 1", rx_empty);
        end
      end
      if (lat_chk && k == 154) begin
        checks++;
        if (rx_empty !== 1'b0 || rd_data !== b) begin
          errors++;
          $display("FAIL push_latency: rx_empty=%b rd_data=%02h expected 0/%02h", rx_empty, rd_data, b);
        end
      end
    end
    rd_en = 1'b0;
    if (stop) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ov = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic pop_one();
    checks++;
    if (rd_data !== q[0]) begin
      errors++;
      $display("FAIL pop_data: got %02h expected %02h", rd_data, q[0]);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_data, rx_empty, rx_full, rx_count, frame_err, overrun} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rd_data=%02h empty=%b full=%b count=%0d fe=%b ov=%b",
               rd_data, rx_empty, rx_full, rx_count, frame_err, overrun);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_empty !== 1'b1 || rx_count !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset: empty=%b count=%0d expected 1/0", rx_empty, rx_count);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h55, 1'b1, 1'b1, -1, -1);
    send_frame(8'hA3, 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rd_data !== 8'h55 || rx_count !== 5'd2) begin
      errors++;
      $display("FAIL basic_two: rd_data=%02h count=%0d expected 55/2", rd_data, rx_count);
    end
    pop_one();
    checks++;
    if (rd_data !== 8'hA3 || rx_count !== 5'd1) begin
      errors++;
      $display("FAIL basic_pop: rd_data=%02h count=%0d expected a3/1", rd_data, rx_count);
    end
    pop_one();
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: rx_empty got %b expected 1", rx_empty);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, -1, -1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_count !== 5'(q.size())) begin
      errors++;
      $display("FAIL random_count: got %0d expected %0d", rx_count, q.size());
    end
    while (q.size() > 0) pop_one();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_full !== 1'b1 || overrun !== exp_ov || rx_count !== 5'(q.size()) || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL overrun_full: full=%b ov=%b count=%0d head=%02h expected 1/%b/%0d/00",
               rx_full, overrun, rx_count, rd_data, exp_ov, q.size());
    end
    for (int i = 0; i < 16; i++) pop_one();
    checks++;
    if (rx_empty !== 1'b1 || rx_count !== 5'd0) begin
      errors++;
      $display("FAIL overrun_drain: empty=%b count=%0d expected 1/0", rx_empty, rx_count);
    end
    pulse_clr();
    checks++;
    if (overrun !== exp_ov) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected %b", overrun, exp_ov);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rx_empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL glitch: empty=%b fe=%b ov=%b expected 1/0/0", rx_empty, frame_err, overrun);
    end
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_count !== 5'd1 || rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL after_glitch: count=%0d rd_data=%02h expected 1/5a", rx_count, rd_data);
    end
    pop_one();
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    checks++;
    if (frame_err !== exp_fe || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_set: fe=%b empty=%b expected %b/1", frame_err, rx_empty, exp_fe);
    end
    repeat (20 * CPB) @(negedge clk);
    pulse_clr();
    repeat (20 * CPB) @(negedge clk);
    checks++;
    if (frame_err !== exp_fe || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL break_hold: fe=%b empty=%b expected %b/1", frame_err, rx_empty, exp_fe);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_count !== 5'd1 || rd_data !== 8'h81 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL after_break: count=%0d rd_data=%02h fe=%b expected 1/81/0", rx_count, rd_data, frame_err);
    end
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    checks++;
    if (frame_err !== exp_fe) begin
      errors++;
      $display("FAIL frame_err_again: got %b expected %b", frame_err, exp_fe);
    end
    pulse_clr();
    checks++;
    if (frame_err !== exp_fe) begin
      errors++;
      $display("FAIL frame_err_clear: got %b expected %b", frame_err, exp_fe);
    end
    pop_one();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_full !== 1'b1) begin
      errors++;
      $display("FAIL prefill_full: got %b expected 1", rx_full);
    end
    send_frame(8'h7E, 1'b1, 1'b0, 153, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_count !== 5'(q.size()) || overrun !== exp_ov || q[DEPTH-1] !== 8'h7E) begin
      errors++;
      $display("FAIL full_pop_push: count=%0d ov=%b expected %0d/%b", rx_count, overrun, q.size(), exp_ov);
    end
    while (q.size() > 0) pop_one();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    send_frame(8'hC3, 1'b1, 1'b0, -1, -1);
    send_frame(8'hF0, 1'b1, 1'b0, -1, 5 * CPB + 8);
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    checks++;
    if ({rd_data, rx_empty, rx_full, rx_count, frame_err, overrun} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rd_data=%02h empty=%b full=%b count=%0d fe=%b ov=%b",
               rd_data, rx_empty, rx_full, rx_count, frame_err, overrun);
    end
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_count !== 5'd1 || rd_data !== b || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_frame: count=%0d rd_data=%02h fe=%b expected 1/%02h/0", rx_count, rd_data, frame_err, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_full_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
